// File: rtl/wb_obi_bridge.sv
// rtl/wb_obi_bridge.sv - Wishbone-classic responder to OBI initiator bridge (optional timeout: WB_OBI_TIMEOUT_EN)
module wb_obi_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
    input  logic [DATA_WIDTH-1:0]   wb_wdata_i,
    input  logic                    wb_wr_en_i,
    input  logic [DATA_WIDTH/8-1:0] wb_byte_en_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [DATA_WIDTH-1:0]   wb_rdata_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ACK} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    skip_q;     // zero-byte write: no OBI access at all
    logic                    drop_q;     // WB master abandoned the cycle
    logic                    timeout_hit;
    logic                    discard_q;
    logic                    start;
    logic                    zero_write;
    logic                    abandoned;

    assign zero_write  = wb_wr_en_i && (wb_byte_en_i == '0);
    assign abandoned   = drop_q || !wb_cyc_i;
    assign start       = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o && !discard_q;

    assign wb_ack_o    = (state_q == S_ACK);
    assign wb_rdata_o  = rdata_q;
    assign obi_req_o   = (state_q == S_REQ);
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = wdata_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a zero-byte write parks one cycle in RESP so its ack lands two cycles after stb
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = zero_write ? S_RESP : S_REQ;
            S_REQ: begin
                if (obi_gnt_i)        state_d = S_RESP;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_RESP: begin
                if (skip_q)            state_d = abandoned ? S_IDLE : S_ACK;
                else if (obi_rvalid_i) state_d = abandoned ? S_IDLE : S_ACK;
                else if (timeout_hit)  state_d = S_IDLE;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, abandon tracking and read-data capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            skip_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                addr_q  <= {wb_addr_i[ADDR_WIDTH-1:2], 2'b00};
                we_q    <= wb_wr_en_i;
                be_q    <= (!wb_wr_en_i && wb_byte_en_i == '0) ? '1 : wb_byte_en_i;
                wdata_q <= wb_wdata_i;
                skip_q  <= zero_write;
                drop_q  <= 1'b0;
            end else if ((state_q == S_REQ || state_q == S_RESP) && !wb_cyc_i) begin
                drop_q  <= 1'b1;
            end
            if (state_q == S_RESP && !skip_q && obi_rvalid_i && !we_q) begin
                rdata_q <= obi_rdata_i;
            end
        end
    end

`ifdef WB_OBI_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             req_abort;
    logic             resp_abort;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign req_abort   = (state_q == S_REQ) && !obi_gnt_i && timeout_hit;
    assign resp_abort  = (state_q == S_RESP) && !skip_q && !obi_rvalid_i && timeout_hit;
    assign wb_err_o    = err_q;

    // Wait counter: restarts on entering REQ or RESP, runs while in either
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_d != state_q && (state_d == S_REQ || state_d == S_RESP)) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_RESP) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Error pulse on abort; a late response after a RESP abort is swallowed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            err_q <= (req_abort || resp_abort) && !abandoned;
            if (resp_abort)                    discard_q <= 1'b1;
            else if (discard_q && obi_rvalid_i) discard_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign discard_q   = 1'b0;
    assign wb_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_obi_bridge.sv
// tb/tb_wb_obi_bridge.sv - directed self-checking bench for wb_obi_bridge
module tb_wb_obi_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_wdata_i;
    logic        wb_wr_en_i;
    logic [3:0]  wb_byte_en_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] wb_rdata_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    wb_obi_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wb_addr_i    (wb_addr_i),
        .wb_wdata_i   (wb_wdata_i),
        .wb_wr_en_i   (wb_wr_en_i),
        .wb_byte_en_i (wb_byte_en_i),
        .wb_stb_i     (wb_stb_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .wb_rdata_o   (wb_rdata_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb_start(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic [3:0] sel);
        wb_addr_i    = addr;
        wb_wdata_i   = wdata;
        wb_wr_en_i   = we;
        wb_byte_en_i = sel;
        wb_stb_i     = 1'b1;
        wb_cyc_i     = 1'b1;
    endtask

    task automatic wb_end;
        wb_stb_i     = 1'b0;
        wb_cyc_i     = 1'b0;
        wb_wr_en_i   = 1'b0;
        wb_byte_en_i = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni       = 1'b0;
        wb_addr_i    = '0;
        wb_wdata_i   = '0;
        wb_wr_en_i   = 1'b0;
        wb_byte_en_i = 4'h0;
        wb_stb_i     = 1'b0;
        wb_cyc_i     = 1'b0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = '0;
        tick;
        tick;
        check("rst_req",   obi_req_o,  0);
        check("rst_ack",   wb_ack_o,   0);
        check("rst_err",   wb_err_o,   0);
        check("rst_rdata", wb_rdata_o, 0);
        check("rst_addr",  obi_addr_o, 0);
        check("rst_be",    obi_be_o,   0);
        rst_ni = 1'b1;
        tick;

        // Read, zero-wait grant, rvalid next cycle: ack at cycle 3
        wb_start(32'h0008_0004, 32'h0, 1'b0, 4'hF);
        check("rd_req_c0", obi_req_o, 0);
        tick;
        check("rd_req_c1", obi_req_o, 1);
        check("rd_addr",   obi_addr_o, 32'h0008_0004);
        check("rd_be",     obi_be_o, 4'hF);
        check("rd_we",     obi_we_o, 0);
        obi_gnt_i = 1'b1;
        tick;
        obi_gnt_i = 1'b0;
        check("rd_req_c2", obi_req_o, 0);
        check("rd_ack_c2", wb_ack_o, 0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'hDEAD_BEEF;
        tick;
        obi_rvalid_i = 1'b0;
        check("rd_ack_c3", wb_ack_o, 1);
        check("rd_rdata",  wb_rdata_o, 32'hDEAD_BEEF);
        wb_end;
        tick;
        check("rd_ack_c4", wb_ack_o, 0);

        // Write, grant delayed 5 cycles: request held stable for 6 cycles
        wb_start(32'h0000_0013, 32'h00AB_0000, 1'b1, 4'b0100);
        for (int i = 1; i <= 6; i++) begin
            tick;
            check("wr_req",   obi_req_o, 1);
            check("wr_addr",  obi_addr_o, 32'h0000_0010);
            check("wr_be",    obi_be_o, 4'b0100);
            check("wr_we",    obi_we_o, 1);
            check("wr_wdata", obi_wdata_o, 32'h00AB_0000);
            if (i == 6) obi_gnt_i = 1'b1;
        end
        tick;
        obi_gnt_i = 1'b0;
        check("wr_req_off", obi_req_o, 0);
        check("wr_ack_early", wb_ack_o, 0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h1234_5678;
        tick;
        obi_rvalid_i = 1'b0;
        check("wr_ack", wb_ack_o, 1);
        check("wr_rdata_kept", wb_rdata_o, 32'hDEAD_BEEF);
        wb_end;
        tick;
        check("wr_ack_once", wb_ack_o, 0);

        // Zero-byte write: no OBI request, ack two cycles after stb
        wb_start(32'h0000_0020, 32'h0000_0055, 1'b1, 4'h0);
        tick;
        check("z_req_c1", obi_req_o, 0);
        check("z_ack_c1", wb_ack_o, 0);
        tick;
        check("z_req_c2", obi_req_o, 0);
        check("z_ack_c2", wb_ack_o, 1);
        wb_end;
        tick;
        check("z_ack_c3", wb_ack_o, 0);

        // Cycle dropped in REQ: request held to grant, response swallowed, no ack
        wb_start(32'h0000_0040, 32'h0, 1'b0, 4'hF);
        tick;
        check("cd_req_c1", obi_req_o, 1);
        wb_end;
        tick;
        check("cd_req_c2", obi_req_o, 1);
        tick;
        check("cd_req_c3", obi_req_o, 1);
        obi_gnt_i = 1'b1;
        tick;
        obi_gnt_i = 1'b0;
        check("cd_req_c4", obi_req_o, 0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h0BAD_F00D;
        tick;
        obi_rvalid_i = 1'b0;
        check("cd_ack_c5", wb_ack_o, 0);
        tick;
        check("cd_ack_c6", wb_ack_o, 0);

        // Reset asserted in RESP: outputs clear at once; later rvalid gives no ack
        wb_start(32'h0000_0080, 32'h0, 1'b0, 4'hF);
        tick;
        check("rr_req_c1", obi_req_o, 1);
        obi_gnt_i = 1'b1;
        tick;
        obi_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("rr_req",   obi_req_o, 0);
        check("rr_ack",   wb_ack_o, 0);
        check("rr_addr",  obi_addr_o, 0);
        check("rr_be",    obi_be_o, 0);
        check("rr_rdata", wb_rdata_o, 0);
        wb_end;
        tick;
        rst_ni = 1'b1;
        tick;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h7777_7777;
        tick;
        obi_rvalid_i = 1'b0;
        check("rr_ack_late", wb_ack_o, 0);
        tick;
        check("rr_ack_late2", wb_ack_o, 0);

        // Read with no byte selects: full-word enable, grant after 1 wait, rvalid after 1 wait
        wb_start(32'h0000_0106, 32'h0, 1'b0, 4'h0);
        tick;
        check("rz_req",  obi_req_o, 1);
        check("rz_be",   obi_be_o, 4'hF);
        check("rz_addr", obi_addr_o, 32'h0000_0104);
        tick;
        obi_gnt_i = 1'b1;
        tick;
        obi_gnt_i = 1'b0;
        check("rz_req_off", obi_req_o, 0);
        tick;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'hCAFE_F00D;
        check("rz_ack_c4", wb_ack_o, 0);
        tick;
        obi_rvalid_i = 1'b0;
        check("rz_ack_c5", wb_ack_o, 1);
        check("rz_rdata",  wb_rdata_o, 32'hCAFE_F00D);
        check("rz_err",    wb_err_o, 0);
        wb_end;
        tick;
        check("rz_ack_c6", wb_ack_o, 0);

`ifdef WB_OBI_TIMEOUT_EN
        // Grant never given: request lasts 16 cycles, then an error pulse
        begin
            int hi;
            hi = 0;
            wb_start(32'h0000_0200, 32'h0, 1'b0, 4'hF);
            for (int i = 1; i <= 16; i++) begin
                tick;
                if (obi_req_o) hi++;
            end
            check("to_req_cycles", hi, 16);
        end
        tick;
        check("to_req_off", obi_req_o, 0);
        check("to_err",     wb_err_o, 1);
        check("to_ack",     wb_ack_o, 0);
        wb_end;
        tick;
        check("to_err_once", wb_err_o, 0);

        // rvalid withheld 16 cycles: error, late rvalid discarded, next read normal
        wb_start(32'h0000_0300, 32'h0, 1'b0, 4'hF);
        tick;
        obi_gnt_i = 1'b1;
        tick;
        obi_gnt_i = 1'b0;
        for (int i = 3; i <= 17; i++) tick;
        check("tr_err_early", wb_err_o, 0);
        tick;
        check("tr_err", wb_err_o, 1);
        check("tr_ack", wb_ack_o, 0);
        wb_end;
        tick;
        check("tr_err_once", wb_err_o, 0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h9999_9999;
        tick;
        obi_rvalid_i = 1'b0;
        check("tr_late_ack",   wb_ack_o, 0);
        check("tr_late_rdata", wb_rdata_o, 32'hCAFE_F00D);
        wb_start(32'h0000_0400, 32'h0, 1'b0, 4'hF);
        tick;
        check("tn_req", obi_req_o, 1);
        obi_gnt_i = 1'b1;
        tick;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h1357_9BDF;
        tick;
        obi_rvalid_i = 1'b0;
        check("tn_ack",   wb_ack_o, 1);
        check("tn_rdata", wb_rdata_o, 32'h1357_9BDF);
        wb_end;
        tick;
        check("tn_ack_once", wb_ack_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
